key_sel_debounce: RTL and testbench

- Front-end for the selectable clock divider.
- Synchronises and debounces four raw push-buttons, then turns a clean press into a registered one-hot 4-bit selection code.
- That code drives the divider's key input directly.
- Guarantees the divider only ever sees a stable one-hot value: never zero, never multi-hot, never glitching.

---
 rtl/key_sel_debounce_if.sv | 20 ++
 rtl/key_sel_debounce.sv | 97 +++++++++
 tb/tb_key_sel_debounce.sv | 129 ++++++++++++
 3 files changed

// File: rtl/key_sel_debounce_if.sv
// Button/selection bundle between the raw push-buttons and the divider key input.
// Optional btn_stable member exists only when KEY_SEL_STATUS_EN is defined.
interface key_sel_debounce_if;
  logic [3:0] btn;
  logic [3:0] key;
  logic       changed;
  logic       sel_state;
`ifdef KEY_SEL_STATUS_EN
  logic [3:0] btn_stable;
`endif

  // No valid/ready here: key is always valid; changed is a one-cycle qualifier marking a new key.
`ifdef KEY_SEL_STATUS_EN
  modport master (output btn, input key, input changed, input sel_state, input btn_stable);
  modport slave  (input btn, output key, output changed, output sel_state, output btn_stable);
`else
  modport master (output btn, input key, input changed, input sel_state);
  modport slave  (input btn, output key, output changed, output sel_state);
`endif
endinterface

// File: rtl/key_sel_debounce.sv
// Synchronise and debounce four push-buttons, then latch a press as a one-hot divider key.
// Define KEY_SEL_STATUS_EN to drive the debounced levels out on bus.btn_stable.
module key_sel_debounce #(
  parameter int         DEB_CYCLES  = 1000000,
  parameter int         CNT_W       = 20,
  parameter logic [3:0] DEFAULT_KEY = 4'b0001
) (
  input logic               clk,
  input logic               rst,
  key_sel_debounce_if.slave bus
);

  typedef enum logic {ARMED = 1'b0, HELD = 1'b1} sel_state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic [3:0]       s1, s2;
  logic [3:0]       stable, stable_d;
  logic [CNT_W-1:0] cnt [4];
  logic [3:0]       press, pick;
  sel_state_t       state, state_nxt;
  logic [3:0]       key_q, key_nxt;
  logic             changed_q, changed_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= bus.btn;
      s2 <= s1;
    end
  end

  // A level is accepted only after DEB_CYCLES uninterrupted cycles away from the stable value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stable   <= '0;
      stable_d <= '0;
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      stable_d <= stable;
      for (int i = 0; i < 4; i++) begin
        if (s2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          stable[i] <= s2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign press = stable & ~stable_d;
  // Two's-complement trick isolates the lowest set bit, giving btn[0] top priority.
  assign pick  = press & (~press + 4'd1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ARMED;
      key_q     <= DEFAULT_KEY;
      changed_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      key_q     <= key_nxt;
      changed_q <= changed_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ARMED:   if (|press) state_nxt = HELD;
      HELD:    if (stable == 4'b0000) state_nxt = ARMED;
      default: state_nxt = ARMED;
    endcase
  end

  always_comb begin
    key_nxt     = key_q;
    changed_nxt = 1'b0;
    if (state == ARMED && (|press) && pick != key_q) begin
      key_nxt     = pick;
      changed_nxt = 1'b1;
    end
  end

  assign bus.key       = key_q;
  assign bus.changed   = changed_q;
  assign bus.sel_state = state;
`ifdef KEY_SEL_STATUS_EN
  assign bus.btn_stable = stable;
`endif

endmodule

// File: tb/tb_key_sel_debounce.sv
// Directed bench for key_sel_debounce with DEB_CYCLES=4: reset, press, bounce, priority, same-key, async reset.
module tb_key_sel_debounce;

  localparam int DEB = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;

  key_sel_debounce_if bus ();

  key_sel_debounce #(
    .DEB_CYCLES (DEB),
    .CNT_W      (3),
    .DEFAULT_KEY(4'b0001)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int vec_cnt = 0;
  int err_cnt = 0;
  logic [3:0] exp_q[$];
  logic [3:0] bpat [12];

  task automatic check_vec(input string tag, input logic [3:0] got, input logic [3:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Advance n rising edges and settle 1 ns past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive b right after an edge and check key/changed for the next 9 edges.
  task automatic run_trace(input string tag, input logic [3:0] b,
                           input logic [3:0] k_old, input logic [3:0] k_new);
    exp_q.delete();
    for (int k = 1; k <= 9; k++) exp_q.push_back((k >= DEB + 3) ? k_new : k_old);
    bus.btn = b;
    for (int k = 1; k <= 9; k++) begin
      step(1);
      check_vec({tag, "_key"}, bus.key, exp_q.pop_front());
      check_vec({tag, "_chg"}, {3'b000, bus.changed},
                (k == DEB + 3 && k_new != k_old) ? 4'd1 : 4'd0);
    end
  endtask

  initial begin
    bus.btn = 4'b0000;
    rst     = 1'b0;

    // Reset state
    step(3);
    check_vec("rst_key", bus.key, 4'b0001);
    check_vec("rst_chg", {3'b000, bus.changed}, 4'd0);
    check_vec("rst_state", {3'b000, bus.sel_state}, 4'd0);
`ifdef KEY_SEL_STATUS_EN
    check_vec("rst_stable", bus.btn_stable, 4'b0000);
`endif
    rst = 1'b1;
    step(2);
    check_vec("post_rst_key", bus.key, 4'b0001);

    // Same-key press: no change, no pulse, but FSM still holds
    run_trace("same", 4'b0001, 4'b0001, 4'b0001);
    check_vec("same_state", {3'b000, bus.sel_state}, 4'd1);
    run_trace("same_rel", 4'b0000, 4'b0001, 4'b0001);
    check_vec("same_rel_state", {3'b000, bus.sel_state}, 4'd0);

    // Clean press then release
    run_trace("clean", 4'b0100, 4'b0001, 4'b0100);
`ifdef KEY_SEL_STATUS_EN
    check_vec("clean_stable", bus.btn_stable, 4'b0100);
`endif
    run_trace("clean_rel", 4'b0000, 4'b0100, 4'b0100);
    check_vec("clean_rel_state", {3'b000, bus.sel_state}, 4'd0);

    // Bounce shorter than DEB_CYCLES is invisible
    bpat = '{4'b1000, 4'b1000, 4'b1000, 4'b0000, 4'b1000, 4'b1000,
             4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    for (int k = 0; k < 12; k++) begin
      bus.btn = bpat[k];
      step(1);
      check_vec("bounce_key", bus.key, 4'b0100);
      check_vec("bounce_chg", {3'b000, bus.changed}, 4'd0);
    end
    check_vec("bounce_state", {3'b000, bus.sel_state}, 4'd0);
    run_trace("bounce_hold", 4'b1000, 4'b0100, 4'b1000);
    step(1);
    check_vec("bounce_hold10", bus.key, 4'b1000);
    run_trace("bounce_rel", 4'b0000, 4'b1000, 4'b1000);

    // Simultaneous press: lowest index wins, others ignored until full release
    run_trace("simul", 4'b1010, 4'b1000, 4'b0010);
    run_trace("simul_drop", 4'b1000, 4'b0010, 4'b0010);
    check_vec("simul_drop_state", {3'b000, bus.sel_state}, 4'd1);
    run_trace("simul_rel", 4'b0000, 4'b0010, 4'b0010);
    check_vec("simul_rel_state", {3'b000, bus.sel_state}, 4'd0);
    run_trace("simul_b3", 4'b1000, 4'b0010, 4'b1000);
    run_trace("simul_b3_rel", 4'b0000, 4'b1000, 4'b1000);

    // Async reset mid-debounce
    bus.btn = 4'b0100;
    step(2);
    #2;
    rst = 1'b0;
    #1;
    check_vec("arst_key", bus.key, 4'b0001);
    check_vec("arst_chg", {3'b000, bus.changed}, 4'd0);
    step(2);
`ifdef KEY_SEL_STATUS_EN
    check_vec("arst_stable", bus.btn_stable, 4'b0000);
`endif
    rst = 1'b1;
    run_trace("arst_rel", 4'b0100, 4'b0001, 4'b0100);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
